// File: rtl/scan_decoder_dual_pkg.sv
// Shared constants and width helpers for the scan_decoder_dual block.
package scan_decoder_dual_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Prescaler width: enough bits to hold DIV-1, never narrower than one bit.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Blank counter width: enough bits to hold BLANK, never narrower than one bit.
  function automatic int blank_width(input int blank);
    return (blank > 0) ? $clog2(blank + 1) : 1;
  endfunction

endpackage

// File: rtl/scan_decoder_dual_dec_onehot_n.sv
// Combinational ADDR_W -> 2**ADDR_W active-low one-hot decoder with enable.
module dec_onehot_n #(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   en_i,
  output logic [(1<<ADDR_W)-1:0] q_n_o
);

  localparam int OUT_W = 1 << ADDR_W;

  // One output per index; low only when enabled and the address matches.
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign q_n_o[i] = ~(en_i && (addr_i == ADDR_W'(i)));
  end

endmodule

// File: rtl/scan_decoder_dual.sv
// Registered dual 2**ADDR_W-way active-low decoder with direct load or
// prescaled scan addressing and a blanking gap after each address change.
module scan_decoder_dual
  import scan_decoder_dual_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DIV    = 4,
  parameter int BLANK  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic                   load,
  input  logic [ADDR_W-1:0]      a_in,
  input  logic                   ea1,
  input  logic                   ea2_n,
  input  logic                   eb1_n,
  input  logic                   eb2_n,
  output logic [(1<<ADDR_W)-1:0] qa_n,
  output logic [(1<<ADDR_W)-1:0] qb_n,
  output logic [ADDR_W-1:0]      addr_out,
  output logic                   wrap
);

  localparam int OUT_W = 1 << ADDR_W;
  localparam int PW    = presc_width(DIV);
  localparam int BW    = blank_width(BLANK);

  localparam logic [PW-1:0]     PRESC_MAX = PW'(DIV - 1);
  localparam logic [BW-1:0]     BLANK_V   = BW'(BLANK);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  // Reject parameter sets that cannot produce a visible decode every step.
  if (DIV < 1) begin : g_bad_div
    $error("scan_decoder_dual: DIV must be >= 1");
  end
  if (BLANK < 0 || BLANK >= DIV) begin : g_bad_blank
    $error("scan_decoder_dual: BLANK must satisfy 0 <= BLANK < DIV");
  end

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic              wrap_q,  wrap_d;
  logic [OUT_W-1:0]  qa_q, qb_q;

  logic              ena, enb;
  logic [BW-1:0]     blank_dec;
  logic [1:0]        dec_en;
  logic [1:0][OUT_W-1:0] dec_n;

  assign ena = ea1 & ~ea2_n;
  assign enb = ~eb1_n & ~eb2_n;

  // Saturating countdown used on every edge that does not reload the gap.
  assign blank_dec = (blank_q != '0) ? (blank_q - BW'(1)) : '0;

  // Next-state for address, prescaler, blank counter and wrap pulse.
  always_comb begin
    addr_d  = addr_q;
    presc_d = '0;
    blank_d = blank_dec;
    wrap_d  = 1'b0;
    if (mode == MODE_SCAN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        addr_d  = addr_q + ADDR_W'(1);
        blank_d = BLANK_V;
        wrap_d  = (addr_q == ADDR_MAX);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (load) begin
      // Reloading the same address must not flash the outputs.
      addr_d = a_in;
      if (a_in != addr_q) blank_d = BLANK_V;
    end
  end

  // Decoders see the next-state address so outputs line up with addr_out.
  assign dec_en[0] = ena & (blank_d == '0);
  assign dec_en[1] = enb & (blank_d == '0);

  for (genvar c = 0; c < 2; c++) begin : g_ch
    dec_onehot_n #(.ADDR_W(ADDR_W)) u_dec (
      .addr_i (addr_d),
      .en_i   (dec_en[c]),
      .q_n_o  (dec_n[c])
    );
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      presc_q <= '0;
      blank_q <= '0;
      wrap_q  <= 1'b0;
      qa_q    <= '1;
      qb_q    <= '1;
    end else begin
      addr_q  <= addr_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
      qa_q    <= dec_n[0];
      qb_q    <= dec_n[1];
    end
  end

  assign qa_n     = qa_q;
  assign qb_n     = qb_q;
  assign addr_out = addr_q;
  assign wrap     = wrap_q;

endmodule
